// File: rtl/adder_32bit_sched_pkg.sv
// Shared definitions for the time-shared 32-bit adder scheduler.
// Holds the sequencing states, the datapath widths and a small helper
// used when the high half of a sum is registered.
package adder_32bit_sched_pkg;

   localparam int HALF_W = 16;
   localparam int DATA_W = 32;

   // IDLE waits for a grant, LO and HI are the two passes through the
   // shared slice, RESP holds the finished result until it is taken.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      RESP = 2'd3
   } adder_sched_state_t;

   // Two's-complement overflow: operands share a sign and the result does not.
   function automatic logic signedOvf(input logic aMsb, input logic bMsb, input logic sumMsb);
      return (aMsb == bMsb) && (sumMsb != aMsb);
   endfunction

endpackage

// File: rtl/adder_32bit_sched_arb.sv
// Round-robin arbiter for the adder scheduler. Purely combinational:
// the search starts at ptr_i and wraps, and the first active request wins.
module adder_rr_arb #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req_i,
   input  logic [$clog2(NREQ)-1:0] ptr_i,
   output logic [NREQ-1:0]         gnt_o,
   output logic [$clog2(NREQ)-1:0] gnt_id_o,
   output logic                    any_o
);

   localparam int IDW = $clog2(NREQ);

   int idx;

   // Walk the requesters in priority order starting at the pointer; once a
   // winner is found the remaining candidates are ignored so gnt stays one-hot.
   always_comb begin
      gnt_o    = '0;
      gnt_id_o = '0;
      any_o    = 1'b0;
      idx      = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr_i) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (!any_o && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            gnt_id_o   = IDW'(idx);
            any_o      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cla_16.sv
// The shared 16-bit carry-lookahead slice that the scheduler time-shares.
// Besides the sum it exports the whole-slice group generate/propagate so
// the caller can form the carry out of the slice for any carry-in.
module CLA_16 (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        c0_i,
   output logic [15:0] sum_o,
   output logic        gx_o,
   output logic        px_o
);

   logic [15:0] bitG;
   logic [15:0] bitP;
   logic [3:0]  grpG;
   logic [3:0]  grpP;
   logic [4:0]  grpC;
   logic [15:0] carry;

   // Per-bit generate/propagate terms feed both lookahead levels.
   always_comb begin
      bitG = a_i & b_i;
      bitP = a_i ^ b_i;
   end

   // First lookahead level: generate/propagate for each 4-bit group.
   always_comb begin
      grpG = '0;
      grpP = '0;
      for (int k = 0; k < 4; k++) begin
         grpG[k] = bitG[4*k+3]
                 | (bitP[4*k+3] & bitG[4*k+2])
                 | (bitP[4*k+3] & bitP[4*k+2] & bitG[4*k+1])
                 | (bitP[4*k+3] & bitP[4*k+2] & bitP[4*k+1] & bitG[4*k]);
         grpP[k] = &bitP[4*k +: 4];
      end
   end

   // Second lookahead level: group carries are formed in parallel from c0,
   // and the whole-slice terms come from the same expressions.
   always_comb begin
      grpC[0] = c0_i;
      grpC[1] = grpG[0] | (grpP[0] & c0_i);
      grpC[2] = grpG[1] | (grpP[1] & grpG[0]) | (grpP[1] & grpP[0] & c0_i);
      grpC[3] = grpG[2] | (grpP[2] & grpG[1]) | (grpP[2] & grpP[1] & grpG[0])
              | (grpP[2] & grpP[1] & grpP[0] & c0_i);
      gx_o    = grpG[3] | (grpP[3] & grpG[2]) | (grpP[3] & grpP[2] & grpG[1])
              | (grpP[3] & grpP[2] & grpP[1] & grpG[0]);
      px_o    = &grpP;
      grpC[4] = gx_o | (px_o & c0_i);
   end

   // Bit carries inside each group start from that group's lookahead carry,
   // then the sum is propagate xor carry.
   always_comb begin
      carry = '0;
      for (int k = 0; k < 4; k++) begin
         carry[4*k] = grpC[k];
         for (int j = 1; j < 4; j++) begin
            carry[4*k+j] = bitG[4*k+j-1] | (bitP[4*k+j-1] & carry[4*k+j-1]);
         end
      end
      sum_o = bitP ^ carry;
   end

endmodule

// File: rtl/adder_32bit_sched.sv
// Time-shared 32-bit adder. Requesters are served one at a time through a
// single CLA_16 slice: the low half is added first, then the high half with
// the carry out of the low half. The result is held until the consumer takes it.
import adder_32bit_sched_pkg::*;

module adder_32bit_sched #(
   parameter int NREQ = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*32-1:0]       req_a,
   input  logic [NREQ*32-1:0]       req_b,
   input  logic [NREQ-1:0]          req_cin,
   output logic [NREQ-1:0]          req_ready,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [$clog2(NREQ)-1:0]  rsp_id,
   output logic [31:0]              rsp_sum,
   output logic                     rsp_cout,
   output logic                     rsp_ovf,
   output logic                     busy
);

   localparam int IDW = $clog2(NREQ);

   adder_sched_state_t state_q, state_d;

   logic [IDW-1:0]    rrPtr_q, rrPtr_d;
   logic [IDW-1:0]    id_q, id_d;
   logic [DATA_W-1:0] opA_q, opA_d;
   logic [DATA_W-1:0] opB_q, opB_d;
   logic              cin_q, cin_d;
   logic [HALF_W-1:0] sumLo_q, sumLo_d;
   logic              c16_q, c16_d;
   logic [IDW-1:0]    rspId_q, rspId_d;
   logic [DATA_W-1:0] rspSum_q, rspSum_d;
   logic              rspCout_q, rspCout_d;
   logic              rspOvf_q, rspOvf_d;

   logic [NREQ-1:0]   gnt;
   logic [IDW-1:0]    gntId;
   logic              gntAny;

   logic [HALF_W-1:0] sliceA;
   logic [HALF_W-1:0] sliceB;
   logic              sliceCin;
   logic [HALF_W-1:0] sliceSum;
   logic              sliceGx;
   logic              slicePx;

   adder_rr_arb #(
      .NREQ (NREQ)
   ) u_arb (
      .req_i    (req_valid),
      .ptr_i    (rrPtr_q),
      .gnt_o    (gnt),
      .gnt_id_o (gntId),
      .any_o    (gntAny)
   );

   CLA_16 u_cla (
      .a_i   (sliceA),
      .b_i   (sliceB),
      .c0_i  (sliceCin),
      .sum_o (sliceSum),
      .gx_o  (sliceGx),
      .px_o  (slicePx)
   );

   // The slice sees the upper operand halves and the saved low-half carry
   // only in HI; every other state presents the low halves and the carry-in.
   always_comb begin
      if (state_q == HI) begin
         sliceA   = opA_q[DATA_W-1:HALF_W];
         sliceB   = opB_q[DATA_W-1:HALF_W];
         sliceCin = c16_q;
      end else begin
         sliceA   = opA_q[HALF_W-1:0];
         sliceB   = opB_q[HALF_W-1:0];
         sliceCin = cin_q;
      end
   end

   // Next-state and datapath captures. Everything holds by default; each state
   // only updates what it owns, so the response registers stay frozen in RESP.
   always_comb begin
      state_d   = state_q;
      rrPtr_d   = rrPtr_q;
      id_d      = id_q;
      opA_d     = opA_q;
      opB_d     = opB_q;
      cin_d     = cin_q;
      sumLo_d   = sumLo_q;
      c16_d     = c16_q;
      rspId_d   = rspId_q;
      rspSum_d  = rspSum_q;
      rspCout_d = rspCout_q;
      rspOvf_d  = rspOvf_q;
      unique case (state_q)
         IDLE: begin
            if (gntAny) begin
               opA_d   = req_a[DATA_W*gntId +: DATA_W];
               opB_d   = req_b[DATA_W*gntId +: DATA_W];
               cin_d   = req_cin[gntId];
               id_d    = gntId;
               rrPtr_d = (gntId == IDW'(NREQ-1)) ? '0 : gntId + 1'b1;
               state_d = LO;
            end
         end
         LO: begin
            sumLo_d = sliceSum;
            c16_d   = sliceGx | (slicePx & cin_q);
            state_d = HI;
         end
         HI: begin
            rspSum_d  = {sliceSum, sumLo_q};
            rspCout_d = sliceGx | (slicePx & c16_q);
            rspOvf_d  = signedOvf(opA_q[DATA_W-1], opB_q[DATA_W-1], sliceSum[HALF_W-1]);
            rspId_d   = id_q;
            state_d   = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset abandons any transaction in flight
   // and clears the visible result, so nothing stale can be presented later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         rrPtr_q   <= '0;
         id_q      <= '0;
         opA_q     <= '0;
         opB_q     <= '0;
         cin_q     <= 1'b0;
         sumLo_q   <= '0;
         c16_q     <= 1'b0;
         rspId_q   <= '0;
         rspSum_q  <= '0;
         rspCout_q <= 1'b0;
         rspOvf_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         rrPtr_q   <= rrPtr_d;
         id_q      <= id_d;
         opA_q     <= opA_d;
         opB_q     <= opB_d;
         cin_q     <= cin_d;
         sumLo_q   <= sumLo_d;
         c16_q     <= c16_d;
         rspId_q   <= rspId_d;
         rspSum_q  <= rspSum_d;
         rspCout_q <= rspCout_d;
         rspOvf_q  <= rspOvf_d;
      end
   end

   // Outputs. The accept strobe is the live grant, but only while idle and
   // out of reset, so it can never be seen mid-transaction or during reset.
   always_comb begin
      req_ready = ((state_q == IDLE) && !rst) ? gnt : '0;
      rsp_valid = (state_q == RESP);
      busy      = (state_q != IDLE);
      rsp_id    = rspId_q;
      rsp_sum   = rspSum_q;
      rsp_cout  = rspCout_q;
      rsp_ovf   = rspOvf_q;
   end

endmodule
